// File: rtl/mw_skid_reg.sv
`default_nettype none
// ============================================================================
//  Module   : mw_skid_reg
//  Purpose  : Memory -> write-back pipeline boundary. Two-entry skid buffer
//             (head H, skid S) behind a valid/ready handshake. Selects the
//             write-back value and register-file write enable at capture
//             time and exports the head entry to the forwarding unit.
//  Options  : MW_LOAD_EXT_EN - when defined, loads are aligned with the
//             address low bits and sign/zero extended here per func3.
//             When undefined, m_valM_i is taken as already extended.
//  Revision : 1.0 - initial release
// ============================================================================
module mw_skid_reg #(
   parameter int CPU_WIDTH = 64,
   parameter int RD_W      = 5
) (
   input  logic                 clk_i,
   input  logic                 rst_n_i,
   input  logic                 flush_i,
   input  logic                 m_valid_i,
   output logic                 m_ready_o,
   input  logic [6:0]           M_opcode_i,
   input  logic [2:0]           M_func3_i,
   input  logic [RD_W-1:0]      M_rd_i,
   input  logic [CPU_WIDTH-1:0] M_valE_i,
   input  logic [CPU_WIDTH-1:0] m_valM_i,
   output logic                 w_valid_o,
   input  logic                 w_ready_i,
   output logic [RD_W-1:0]      W_rd_o,
   output logic [CPU_WIDTH-1:0] W_wdata_o,
   output logic                 W_wen_o,
   output logic                 fwd_valid_o
);

   localparam logic [6:0] OP_IIL = 7'b0000011;

   // Occupancy: the valid bits of H and S are implied by the state.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic                  ready_q, ready_d;
   logic [RD_W-1:0]       h_rd_q, h_rd_d, s_rd_q, s_rd_d;
   logic [CPU_WIDTH-1:0]  h_wdata_q, h_wdata_d, s_wdata_q, s_wdata_d;
   logic                  h_wen_q, h_wen_d, s_wen_q, s_wen_d;

   logic                  in_wen;
   logic [CPU_WIDTH-1:0]  in_wdata;
   logic                  accept;
   logic                  release_h;

   assign accept    = m_valid_i & ready_q;
   assign release_h = (state_q != ST_EMPTY) & w_ready_i;

`ifdef MW_LOAD_EXT_EN
   logic [CPU_WIDTH-1:0] aligned;
   assign aligned = m_valM_i >> {M_valE_i[2:0], 3'b000};
`else
   // Address low bits and func3 have no role when loads arrive pre-extended.
   logic unused_func3;
   assign unused_func3 = ^M_func3_i;
`endif

   // Decode the incoming instruction into its write-back value and enable.
   always_comb begin
      in_wen   = 1'b0;
      in_wdata = M_valE_i;
      case (M_opcode_i)
         7'b0110011, 7'b0010011, 7'b0000011, 7'b0110111, 7'b0010111,
         7'b1101111, 7'b1100111, 7'b0111011, 7'b0011011: in_wen = 1'b1;
         default:                                        in_wen = 1'b0;
      endcase
      if (M_opcode_i == OP_IIL) begin
`ifdef MW_LOAD_EXT_EN
         case (M_func3_i)
            3'b000:  in_wdata = {{(CPU_WIDTH-8){aligned[7]}},   aligned[7:0]};
            3'b001:  in_wdata = {{(CPU_WIDTH-16){aligned[15]}}, aligned[15:0]};
            3'b010:  in_wdata = {{(CPU_WIDTH-32){aligned[31]}}, aligned[31:0]};
            3'b011:  in_wdata = aligned;
            3'b100:  in_wdata = {{(CPU_WIDTH-8){1'b0}},  aligned[7:0]};
            3'b101:  in_wdata = {{(CPU_WIDTH-16){1'b0}}, aligned[15:0]};
            3'b110:  in_wdata = {{(CPU_WIDTH-32){1'b0}}, aligned[31:0]};
            default: begin
               // Reserved load width: produce nothing and never write.
               in_wdata = '0;
               in_wen   = 1'b0;
            end
         endcase
`else
         in_wdata = m_valM_i;
`endif
      end
      if (M_rd_i == '0) in_wen = 1'b0;
   end

   // Next occupancy and entry contents; flush overrides any accept.
   always_comb begin
      state_d   = state_q;
      h_rd_d    = h_rd_q;
      h_wdata_d = h_wdata_q;
      h_wen_d   = h_wen_q;
      s_rd_d    = s_rd_q;
      s_wdata_d = s_wdata_q;
      s_wen_d   = s_wen_q;
      case (state_q)
         ST_EMPTY: begin
            if (accept) begin
               state_d   = ST_ONE;
               h_rd_d    = M_rd_i;
               h_wdata_d = in_wdata;
               h_wen_d   = in_wen;
            end
         end
         ST_ONE: begin
            if (accept && release_h) begin
               h_rd_d    = M_rd_i;
               h_wdata_d = in_wdata;
               h_wen_d   = in_wen;
            end else if (accept) begin
               state_d   = ST_FULL;
               s_rd_d    = M_rd_i;
               s_wdata_d = in_wdata;
               s_wen_d   = in_wen;
            end else if (release_h) begin
               state_d   = ST_EMPTY;
            end
         end
         ST_FULL: begin
            if (release_h) begin
               state_d   = ST_ONE;
               h_rd_d    = s_rd_q;
               h_wdata_d = s_wdata_q;
               h_wen_d   = s_wen_q;
               s_rd_d    = '0;
               s_wdata_d = '0;
               s_wen_d   = 1'b0;
            end
         end
         default: state_d = ST_EMPTY;
      endcase
      if (flush_i) state_d = ST_EMPTY;
      // Registered ready: low only while the skid entry is occupied.
      ready_d = (state_d != ST_FULL);
   end

   // State and entry registers with asynchronous clear.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q   <= ST_EMPTY;
         ready_q   <= 1'b1;
         h_rd_q    <= '0;
         h_wdata_q <= '0;
         h_wen_q   <= 1'b0;
         s_rd_q    <= '0;
         s_wdata_q <= '0;
         s_wen_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         ready_q   <= ready_d;
         h_rd_q    <= h_rd_d;
         h_wdata_q <= h_wdata_d;
         h_wen_q   <= h_wen_d;
         s_rd_q    <= s_rd_d;
         s_wdata_q <= s_wdata_d;
         s_wen_q   <= s_wen_d;
      end
   end

   assign m_ready_o   = ready_q;
   assign w_valid_o   = (state_q != ST_EMPTY);
   assign W_rd_o      = h_rd_q;
   assign W_wdata_o   = h_wdata_q;
   assign W_wen_o     = w_valid_o & h_wen_q;
   assign fwd_valid_o = W_wen_o;

endmodule
`default_nettype wire
